uart_rx: RTL and testbench

//   UART receiver, 8N1 by default: the downstream partner of the UART transmitter.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/baud_tick_gen.sv | 50 +++++
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// Imported by the receive path and by the shared baud tick generator.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Ticks per bit period.
    localparam int unsigned OVERSAMPLE = 16;

    // Sample count at the middle of the start bit (7 ticks after the edge).
    localparam logic [3:0] MID_SAMPLE = 4'd7;

    // Sample count that completes one full bit period.
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

endpackage : uart_pkg

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator.
// Produces a one-clock s_tick every DIV clocks. It is never restarted, so the
// Rx and Tx paths can share one instance.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   s_tick out one-clock pulse each time the counter wraps
module baud_tick_gen #(
    parameter int unsigned DIV = 54
) (
    input  logic clk,
    input  logic rst_n,
    output logic s_tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Next counter value and wrap detection.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            tick_d = 1'b0;
        end
    end

    // Counter and registered tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign s_tick = tick_q;

endmodule : baud_tick_gen

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, LSB first, one stop bit.
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   rx            in   serial input, idle high, asynchronous to clk
//   rx_data       out  last correctly framed byte (bit0 = first received bit)
//   rx_done_tick  out  one-cycle pulse when rx_data is updated
//   frame_err     out  one-cycle pulse when the stop bit is sampled low
//   rx_busy       out  high while a frame is being received
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned DBIT     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            rx_busy
);

    localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned NW  = $clog2(DBIT);
    localparam logic [NW-1:0] LAST_BIT = NW'(DBIT - 1);

    logic            s_tick;
    logic            sync1_q;
    logic            sync2_q;
    logic            rx_s;
    rx_state_t       state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic [DBIT-1:0] rx_data_q, rx_data_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    baud_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_tick (s_tick)
    );

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Next-state and datapath decisions; pulses default low every cycle.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        shreg_d   = shreg_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == MID_SAMPLE) begin
                        // Still low at mid start bit: a real start, otherwise a glitch.
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = 4'd0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == LAST_SAMPLE) begin
                        shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                        s_d     = 4'd0;
                        if (n_q == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == LAST_SAMPLE) begin
                        // Leaving at mid stop bit lets the next start edge follow directly.
                        state_d = IDLE;
                        if (rx_s) begin
                            rx_data_d = shreg_q;
                            done_d    = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_q       <= 4'd0;
            n_q       <= '0;
            shreg_q   <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            shreg_q   <= shreg_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign rx_busy      = (state_q != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BAUD=625_000 (DIV=10, 160 clocks per bit).
module tb_uart_rx;

    localparam int BIT_CLKS = 160;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       frame_err;
    logic       rx_busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         ferr_cnt = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .CLK_FREQ (100_000_000),
        .BAUD     (625_000),
        .DBIT     (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture DUT output events on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_done_tick) got_q.push_back(rx_data);
            if (frame_err) ferr_cnt = ferr_cnt + 1;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive one frame; good frames are pushed to the scoreboard up front.
    task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input int stop_clks);
        if (stop_bit) begin
            exp_q.push_back(d);
            last_good = d;
        end
        @(posedge clk);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop_bit;
        wait_clks(stop_clks);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rx    = 1'b1;
        rst_n = 1'b0;
        #20;
        @(negedge clk);
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
        n_cmp++; if (rx_done_tick !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", rx_done_tick); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        rst_n = 1'b1;
        wait_clks(40);
    endtask

    task automatic test_frame_a5();
        logic [7:0] e;
        int f0 = ferr_cnt;
        drive_frame(8'hA5, 1'b1, BIT_CLKS);
        wait_clks(40);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL a5_count: got %0d pulses want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (got_q[0] !== e) begin n_bad++; $display("FAIL a5_data: got %h want %h", got_q[0], e); end
            void'(got_q.pop_front());
        end
        n_cmp++; if (ferr_cnt != f0) begin n_bad++; $display("FAIL a5_ferr: got %0d want %0d", ferr_cnt - f0, 0); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL a5_busy: got %b want 0", rx_busy); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_glitch();
        int f0 = ferr_cnt;
        @(posedge clk);
        rx = 1'b0;
        wait_clks(30);
        @(negedge clk);
        n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_hi: got %b want 1", rx_busy); end
        @(posedge clk);
        rx = 1'b1;
        wait_clks(120);
        @(negedge clk);
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_lo: got %b want 0", rx_busy); end
        n_cmp++; if (got_q.size() != 0 || ferr_cnt != f0) begin n_bad++; $display("FAIL glitch_pulses: got %0d done %0d ferr want 0 0", got_q.size(), ferr_cnt - f0); end
        got_q.delete();
        wait_clks(40);
    endtask

    task automatic test_frame_error();
        int f0 = ferr_cnt;
        // Stop held low past mid-bit only, so the released line is not read as a new start.
        drive_frame(8'h3C, 1'b0, 100);
        wait_clks(300);
        n_cmp++; if (ferr_cnt - f0 != 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL ferr_done: got %0d pulses want 0", got_q.size()); end
        n_cmp++; if (rx_data !== last_good) begin n_bad++; $display("FAIL ferr_data_hold: got %h want %h", rx_data, last_good); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy: got %b want 0", rx_busy); end
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        int f0 = ferr_cnt;
        drive_frame(8'h00, 1'b1, BIT_CLKS);
        drive_frame(8'hFF, 1'b1, BIT_CLKS);
        wait_clks(40);
        n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL b2b_count: got %0d pulses want 2", got_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) begin
                n_cmp++; if (got_q[0] !== e) begin n_bad++; $display("FAIL b2b_data: got %h want %h", got_q[0], e); end
                void'(got_q.pop_front());
            end else begin
                n_cmp++; n_bad++; $display("FAIL b2b_missing: got none want %h", e);
            end
        end
        n_cmp++; if (rx_data !== 8'hFF) begin n_bad++; $display("FAIL b2b_final: got %h want ff", rx_data); end
        n_cmp++; if (ferr_cnt != f0) begin n_bad++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt - f0); end
        got_q.delete();
    endtask

    task automatic test_reset_abort();
        logic [7:0] partial;
        logic [7:0] e;
        int f0 = ferr_cnt;
        partial = 8'h33;
        @(posedge clk);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            wait_clks(BIT_CLKS);
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        #20;
        @(negedge clk);
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", rx_busy); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL abort_data: got %h want 00", rx_data); end
        rst_n = 1'b1;
        wait_clks(2 * BIT_CLKS);
        n_cmp++; if (got_q.size() != 0 || ferr_cnt != f0) begin n_bad++; $display("FAIL abort_pulses: got %0d done %0d ferr want 0 0", got_q.size(), ferr_cnt - f0); end
        got_q.delete();
        drive_frame(8'h5A, 1'b1, BIT_CLKS);
        wait_clks(40);
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL abort_count: got %0d pulses want 1", got_q.size()); end
        if (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (got_q[0] !== e) begin n_bad++; $display("FAIL abort_next: got %h want %h", got_q[0], e); end
        end
        n_cmp++; if (rx_data !== 8'h5A) begin n_bad++; $display("FAIL abort_final: got %h want 5a", rx_data); end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        rx    = 1'b1;
        rst_n = 1'b1;
        test_reset();
        test_frame_a5();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_rx
